// File: rtl/axil_ram_pipe_if.sv
// ---------------------------------------------------------------------------
// axil_ram_pipe_if
//   AXI4-Lite bus bundle between one master and the axil_ram_pipe slave.
//
//   Parameters : DATA_WIDTH, ADDR_WIDTH, STRB_WIDTH (must match the slave).
//   Signals    : aw* (write address), w* (write data), b* (write response),
//                ar* (read address), r* (read data), all AXI4-Lite named.
//   Modports   : master -- drives addresses, data, valids and bready/rready.
//                slave  -- drives readys, responses and read data.
//
//   Handshake rule on every channel: a beat transfers on the rising clock
//   edge where valid and ready are both high.  A source holds valid and its
//   payload stable until that edge; ready may rise or fall freely and never
//   depends combinationally on the valid of the same channel.
// ---------------------------------------------------------------------------
interface axil_ram_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;

    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_ram_pipe.sv
// ---------------------------------------------------------------------------
// axil_ram_pipe
//   AXI4-Lite slave backed by a byte-writable word RAM with a 1- or 2-stage
//   read pipeline.  Read and write channels run fully concurrently.
//
//   Ports:
//     clk    -- single clock, rising edge
//     rst_n  -- asynchronous active-low reset (RAM contents are not reset)
//     s_axil -- AXI4-Lite slave bundle (axil_ram_pipe_if.slave)
//
//   Write path: AW and W are each captured in a one-entry hold.  When both
//   holds are full and the response slot is free (or being drained this
//   edge) the write commits: strobed bytes update, holds clear, bvalid rises.
//   Words at or above MEM_WORDS are never written and answer SLVERR.
//
//   Read path: the RAM is sampled on the AR handshake edge.  READ_LATENCY=1
//   loads the R output register directly; READ_LATENCY=2 inserts one stage
//   that drains into the output register whenever it is empty or accepted.
//   Out-of-range reads return zero data with SLVERR.
//
//   Readys stay low until the first clock edge after reset release.
// ---------------------------------------------------------------------------
module axil_ram_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int MEM_WORDS    = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    axil_ram_pipe_if.slave s_axil
);
    localparam int ADDR_LSB = $clog2(STRB_WIDTH);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam int MEM_AW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return 32'(idx) < 32'(MEM_WORDS);
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    // Low until the first edge after reset release; gates every ready.
    logic run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run <= 1'b0;
        else        run <= 1'b1;
    end

    // -----------------------------------------------------------------------
    // Write path
    // -----------------------------------------------------------------------
    logic                  aw_full;
    logic [IDX_W-1:0]      aw_idx;
    logic                  w_full;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  commit;

    assign s_axil.awready = run && !aw_full;
    assign s_axil.wready  = run && !w_full;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;

    assign aw_hs  = s_axil.awvalid && s_axil.awready;
    assign w_hs   = s_axil.wvalid && s_axil.wready;
    // A pending response that is being accepted this edge frees the slot.
    assign commit = aw_full && w_full && (!bvalid_q || s_axil.bready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_full  <= 1'b0;
            aw_idx   <= '0;
            w_full   <= 1'b0;
            w_data   <= '0;
            w_strb   <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            // A hold only accepts when empty and only commits when full,
            // so the load and clear conditions never coincide.
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_idx  <= s_axil.awaddr[ADDR_WIDTH-1:ADDR_LSB];
            end else if (commit) begin
                aw_full <= 1'b0;
            end

            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= s_axil.wdata;
                w_strb <= s_axil.wstrb;
            end else if (commit) begin
                w_full <= 1'b0;
            end

            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= in_range(aw_idx) ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axil.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // RAM write port; intentionally outside the reset domain.
    always_ff @(posedge clk) begin
        if (commit && in_range(aw_idx)) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (w_strb[i]) mem[aw_idx[MEM_AW-1:0]][8*i +: 8] <= w_data[8*i +: 8];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read path
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0]      ar_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [1:0]            rd_resp;
    logic                  arready_int;
    logic                  ar_hs;
    logic                  out_adv;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;

    assign ar_idx  = s_axil.araddr[ADDR_WIDTH-1:ADDR_LSB];
    // The write port uses non-blocking updates, so a read handshake on the
    // same edge as a commit to that word sees the old contents.
    assign rd_word = in_range(ar_idx) ? mem[ar_idx[MEM_AW-1:0]] : '0;
    assign rd_resp = in_range(ar_idx) ? RESP_OKAY : RESP_SLVERR;

    // Output register may take new data this edge.
    assign out_adv = !rvalid_q || s_axil.rready;
    assign ar_hs   = s_axil.arvalid && arready_int;

    assign s_axil.arready = arready_int;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rdata   = rdata_q;
    assign s_axil.rresp   = rresp_q;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  s1_valid;
            logic [DATA_WIDTH-1:0] s1_data;
            logic [1:0]            s1_resp;

            // Accept when the stage is empty or will drain into the output.
            assign arready_int = run && (!s1_valid || out_adv);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_valid <= 1'b0;
                    s1_data  <= '0;
                    s1_resp  <= RESP_OKAY;
                    rvalid_q <= 1'b0;
                    rdata_q  <= '0;
                    rresp_q  <= RESP_OKAY;
                end else begin
                    if (out_adv) begin
                        rvalid_q <= s1_valid;
                        if (s1_valid) begin
                            rdata_q <= s1_data;
                            rresp_q <= s1_resp;
                        end
                    end

                    if (ar_hs) begin
                        s1_valid <= 1'b1;
                        s1_data  <= rd_word;
                        s1_resp  <= rd_resp;
                    end else if (out_adv) begin
                        s1_valid <= 1'b0;
                    end
                end
            end
        end else begin : g_lat1
            assign arready_int = run && out_adv;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rvalid_q <= 1'b0;
                    rdata_q  <= '0;
                    rresp_q  <= RESP_OKAY;
                end else if (ar_hs) begin
                    rvalid_q <= 1'b1;
                    rdata_q  <= rd_word;
                    rresp_q  <= rd_resp;
                end else if (s_axil.rready) begin
                    rvalid_q <= 1'b0;
                end
            end
        end
    endgenerate

    // Protection bits and sub-word address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{s_axil.awprot, s_axil.arprot, s_axil.awaddr, s_axil.araddr};

endmodule

// File: tb/tb_axil_ram_pipe.sv
// ---------------------------------------------------------------------------
// tb_axil_ram_pipe
//   Directed + randomized bench for axil_ram_pipe (READ_LATENCY=2 build).
//   A word-array reference model applies the byte-strobe / range rules
//   directly; expected read beats queue up in exp_q.
// ---------------------------------------------------------------------------
module tb_axil_ram_pipe;
    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int SW    = DW / 8;
    localparam int WORDS = 1024;
    localparam int LAT   = 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    axil_ram_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) bus ();

    axil_ram_pipe #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .STRB_WIDTH  (SW),
        .MEM_WORDS   (WORDS),
        .READ_LATENCY(LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_axil(bus)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / model ----------------
    int total = 0;
    int bad   = 0;

    logic [DW-1:0]   model_mem [WORDS];
    logic [DW+1:0]   exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW+1:0] model_read(input logic [AW-1:0] addr);
        int idx;
        idx = int'(addr) / SW;
        if (idx < WORDS) return {2'b00, model_mem[idx]};
        return {2'b10, {DW{1'b0}}};
    endfunction

    function automatic logic [1:0] model_write(input logic [AW-1:0] addr,
                                               input logic [DW-1:0] data,
                                               input logic [SW-1:0] strb);
        int idx;
        idx = int'(addr) / SW;
        if (idx >= WORDS) return 2'b10;
        for (int b = 0; b < SW; b++) begin
            if (strb[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
        end
        return 2'b00;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_bus();
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b1;
    endtask

    // Entered at a negedge; waits for one B beat, leaves after the edge that takes it.
    task automatic wait_b(input string tag, input logic [1:0] exp_resp);
        logic seen;
        seen = 1'b0;
        for (int g = 0; g < 20 && !seen; g++) begin
            if (bus.bvalid) seen = 1'b1;
            else begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        check({tag, "_seen"}, seen, 1'b1);
        check(tag, bus.bresp, exp_resp);
        @(posedge clk);
    endtask

    // Entered at a negedge; waits for one R beat and checks it.
    task automatic wait_r(input string tag, input logic [DW+1:0] e,
                          output logic [DW-1:0] d, output logic [1:0] r);
        logic seen;
        seen = 1'b0;
        d = '0;
        r = '0;
        for (int g = 0; g < 20 && !seen; g++) begin
            if (bus.rvalid && bus.rready) begin
                seen = 1'b1;
                d = bus.rdata;
                r = bus.rresp;
            end else begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        check({tag, "_seen"}, seen, 1'b1);
        check({tag, "_data"}, d, e[DW-1:0]);
        check({tag, "_resp"}, r, e[DW+1:DW]);
        @(posedge clk);
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [SW-1:0] strb);
        logic aw_done, w_done, a_hs, d_hs;
        logic [1:0] exp_resp;
        aw_done = 1'b0;
        w_done  = 1'b0;
        @(negedge clk);
        bus.awvalid = 1'b1; bus.awaddr = addr; bus.awprot = 3'($urandom_range(0, 7));
        bus.wvalid = 1'b1; bus.wdata = data; bus.wstrb = strb;
        for (int g = 0; g < 20 && !(aw_done && w_done); g++) begin
            #1;
            a_hs = bus.awvalid && bus.awready;
            d_hs = bus.wvalid && bus.wready;
            @(posedge clk);
            if (a_hs) aw_done = 1'b1;
            if (d_hs) w_done = 1'b1;
            @(negedge clk);
            if (aw_done) bus.awvalid = 1'b0;
            if (w_done) bus.wvalid = 1'b0;
        end
        check("wr_accept", {aw_done, w_done}, 2'b11);
        exp_resp = model_write(addr, data, strb);
        wait_b("wr_bresp", exp_resp);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, output logic [DW-1:0] d,
                           output logic [1:0] r);
        logic done, hs;
        done = 1'b0;
        @(negedge clk);
        bus.arvalid = 1'b1; bus.araddr = addr; bus.arprot = 3'($urandom_range(0, 7));
        for (int g = 0; g < 20 && !done; g++) begin
            #1;
            hs = bus.arvalid && bus.arready;
            @(posedge clk);
            if (hs) done = 1'b1;
            @(negedge clk);
            if (done) bus.arvalid = 1'b0;
        end
        check("rd_accept", done, 1'b1);
        wait_r("rd", model_read(addr), d, r);
    endtask

    // Back-to-back reads; optional 3-cycle rready stall after the third beat.
    task automatic burst(input logic [AW-1:0] addrs [8], input bit stall, input bit timing);
        int hs0;
        int got;
        int beat_cyc [8];
        hs0 = 0;
        got = 0;
        fork
            begin : drv
                int  i;
                logic hs;
                i = 0;
                @(negedge clk);
                for (int g = 0; g < 100 && i < 8; g++) begin
                    bus.arvalid = 1'b1;
                    bus.araddr  = addrs[i];
                    #1;
                    hs = bus.arready;
                    if (hs && i == 0) hs0 = cyc;
                    @(posedge clk);
                    if (hs) begin
                        exp_q.push_back(model_read(addrs[i]));
                        i++;
                    end
                    @(negedge clk);
                end
                bus.arvalid = 1'b0;
            end
            begin : mon
                int stall_cnt;
                logic held_v;
                logic [DW+1:0] held, e;
                stall_cnt = 0;
                held_v = 1'b0;
                held = '0;
                for (int g = 0; g < 100 && got < 8; g++) begin
                    @(negedge clk);
                    if (stall && got == 3 && stall_cnt < 3) begin
                        bus.rready = 1'b0;
                        stall_cnt++;
                    end else begin
                        bus.rready = 1'b1;
                    end
                    if (bus.rvalid) begin
                        if (held_v) check("burst_hold", {bus.rresp, bus.rdata}, held);
                        if (bus.rready) begin
                            e = (exp_q.size() > 0) ? exp_q.pop_front() : {(DW+2){1'bx}};
                            check("burst_beat", {bus.rresp, bus.rdata}, e);
                            beat_cyc[got] = cyc;
                            got++;
                            held_v = 1'b0;
                        end else begin
                            held   = {bus.rresp, bus.rdata};
                            held_v = 1'b1;
                        end
                    end
                end
                bus.rready = 1'b1;
            end
        join
        check("burst_count", got, 8);
        check("burst_q_empty", exp_q.size(), 0);
        if (timing && got == 8) begin
            check("burst_first_latency", beat_cyc[0] - hs0, LAT);
            check("burst_span", beat_cyc[7] - beat_cyc[0], 7);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [DW-1:0] d;
        logic [1:0]    r;
        logic [DW+1:0] e;
        logic [AW-1:0] baddr [8];
        logic [1:0]    er;
        logic          seen;

        idle_bus();
        for (int i = 0; i < WORDS; i++) model_mem[i] = '0;

        // Reset values
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", bus.awready, 1'b0);
        check("rst_wready", bus.wready, 1'b0);
        check("rst_arready", bus.arready, 1'b0);
        check("rst_bvalid", bus.bvalid, 1'b0);
        check("rst_rvalid", bus.rvalid, 1'b0);
        check("rst_bresp", bus.bresp, 2'b00);
        check("rst_rresp", bus.rresp, 2'b00);
        check("rst_rdata", bus.rdata, 32'h0);
        rst_n = 1'b1;
        #1 check("run_before_edge", bus.awready, 1'b0);
        @(posedge clk);
        #1;
        check("run_awready", bus.awready, 1'b1);
        check("run_wready", bus.wready, 1'b1);
        check("run_arready", bus.arready, 1'b1);

        // Bring the words the bench touches to a known value
        for (int w = 0; w < 32; w++) do_write(AW'(w * SW), '0, '1);

        // AW first, W three cycles later, bready held low for a while
        @(negedge clk);
        bus.awvalid = 1'b1; bus.awaddr = 16'h0010;
        #1 check("c26_awready", bus.awready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.bready  = 1'b0;
        check("c26_aw_held", bus.awready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("c26_no_b_without_w", bus.bvalid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.wvalid = 1'b1; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF;
        #1 check("c26_wready", bus.wready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.wvalid = 1'b0;
        check("c26_b_not_yet", bus.bvalid, 1'b0);
        @(posedge clk);
        #1;
        er = model_write(16'h0010, 32'hDEADBEEF, 4'hF);
        check("c26_bvalid", bus.bvalid, 1'b1);
        check("c26_bresp", bus.bresp, er);
        @(negedge clk);
        @(posedge clk);
        #1;
        check("c26_b_hold", bus.bvalid, 1'b1);
        check("c26_b_hold_resp", bus.bresp, er);
        check("c26_aw_refill_ok", bus.awready, 1'b1);
        @(negedge clk);
        bus.bready = 1'b1;
        @(posedge clk);
        #1 check("c26_b_drained", bus.bvalid, 1'b0);
        do_read(16'h0010, d, r);
        check("c26_rdata_const", d, 32'hDEADBEEF);

        // Partial strobes
        do_write(16'h0000, 32'h11223344, 4'b0101);
        do_read(16'h0000, d, r);
        check("c27_rdata_const", d, 32'h00220044);

        // Out-of-range write and read, memory untouched
        do_write(16'h1000, 32'hA5A5A5A5, 4'hF);
        do_read(16'h1000, d, r);
        check("c28_rresp_const", r, 2'b10);
        check("c28_rdata_const", d, 32'h0);
        do_read(16'h0000, d, r);
        check("c28_word0_unchanged", d, 32'h00220044);

        // Zero strobes: legal, no change
        do_write(16'h0000, 32'hFFFFFFFF, 4'h0);
        do_read(16'h0003, d, r);
        check("c14_zero_strb", d, 32'h00220044);

        // Read and commit to the same word on the same edge
        do_write(16'h0020, 32'h5, 4'hF);
        @(negedge clk);
        bus.awvalid = 1'b1; bus.awaddr = 16'h0020;
        @(posedge clk);
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid = 1'b1; bus.wdata = 32'h77778888; bus.wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        bus.wvalid  = 1'b0;
        bus.arvalid = 1'b1; bus.araddr = 16'h0020;
        #1 check("c30_arready", bus.arready, 1'b1);
        e = model_read(16'h0020);
        @(posedge clk);
        #1 check("c30_commit_bvalid", bus.bvalid, 1'b1);
        er = model_write(16'h0020, 32'h77778888, 4'hF);
        check("c30_bresp", bus.bresp, er);
        @(negedge clk);
        bus.arvalid = 1'b0;
        wait_r("c30_old", e, d, r);
        check("c30_old_const", d, 32'h5);
        do_read(16'h0020, d, r);
        check("c30_new_const", d, 32'h77778888);

        // Back-to-back reads, then a burst with a mid-burst rready stall
        for (int i = 0; i < 8; i++) baddr[i] = AW'($urandom_range(0, 31) * SW);
        burst(baddr, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) baddr[i] = AW'($urandom_range(0, 31) * SW + $urandom_range(0, 3));
        baddr[5] = 16'h2000;
        burst(baddr, 1'b1, 1'b0);

        // Randomized mix of single writes and reads
        for (int k = 0; k < 60; k++) begin
            int w;
            logic [AW-1:0] a;
            w = ($urandom_range(0, 9) == 0) ? int'($urandom_range(WORDS, 16383)) : int'($urandom_range(0, 31));
            a = AW'(w * SW + int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) do_write(a, $urandom, SW'($urandom_range(0, 15)));
            else do_read(a, d, r);
        end

        // Reset with an AW held and a read in flight
        @(negedge clk);
        bus.awvalid = 1'b1; bus.awaddr = 16'h0030;
        @(posedge clk);
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.rready  = 1'b0;
        bus.arvalid = 1'b1; bus.araddr = 16'h0034;
        @(posedge clk);
        @(negedge clk);
        bus.arvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("c31_rvalid_before", bus.rvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("c31_awready", bus.awready, 1'b0);
        check("c31_wready", bus.wready, 1'b0);
        check("c31_arready", bus.arready, 1'b0);
        check("c31_bvalid", bus.bvalid, 1'b0);
        check("c31_rvalid", bus.rvalid, 1'b0);
        check("c31_rdata", bus.rdata, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rready = 1'b1;
        #1 check("c31_not_yet_ready", bus.arready, 1'b0);
        @(posedge clk);
        #1;
        check("c31_awready_back", bus.awready, 1'b1);
        check("c31_wready_back", bus.wready, 1'b1);
        check("c31_arready_back", bus.arready, 1'b1);
        check("c31_rvalid_clear", bus.rvalid, 1'b0);

        // Held AW must be gone: W alone produces no response
        @(negedge clk);
        bus.wvalid = 1'b1; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        bus.wvalid = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1 if (bus.bvalid) seen = 1'b1;
        end
        check("c31_no_stale_commit", seen, 1'b0);
        @(negedge clk);
        bus.awvalid = 1'b1; bus.awaddr = 16'h0034;
        @(posedge clk);
        @(negedge clk);
        bus.awvalid = 1'b0;
        er = model_write(16'h0034, 32'hCAFEF00D, 4'hF);
        wait_b("c31_late_bresp", er);
        do_read(16'h0030, d, r);
        do_read(16'h0034, d, r);
        check("c31_new_const", d, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
